// File: rtl/clasificador_boton_if.sv
// -----------------------------------------------------------------------------
// clasificador_boton_if
//   Bundles the debounced button level with the event outputs of one
//   clasificador_boton instance.
//   Signals:
//     boton_limpio  debounced button level, 1 = pressed
//     press_short   one-cycle pulse, press released before the long threshold
//     press_long    one-cycle pulse, hold reached the long threshold
//     press_repeat  one-cycle pulse, periodic while held after press_long
//     pulsado       level, 1 while a press is being tracked
//   Modports:
//     master  drives boton_limpio, observes the events (debouncer / bench side)
//     slave   consumes boton_limpio, produces the events (classifier side)
// -----------------------------------------------------------------------------
interface clasificador_boton_if;
   logic boton_limpio;
   logic press_short;
   logic press_long;
   logic press_repeat;
   logic pulsado;

   modport master (
      output boton_limpio,
      input  press_short,
      input  press_long,
      input  press_repeat,
      input  pulsado
   );

   modport slave (
      input  boton_limpio,
      output press_short,
      output press_long,
      output press_repeat,
      output pulsado
   );
endinterface

// File: rtl/clasificador_boton.sv
// -----------------------------------------------------------------------------
// clasificador_boton
//   Turns a clean button level into one-cycle short / long / repeat events.
//   Ports:
//     clk     system clock, all logic on posedge
//     rst     synchronous active-high reset
//     io_btn  slave side of clasificador_boton_if
//               boton_limpio (in), press_short / press_long / press_repeat /
//               pulsado (out, all registered)
//   Parameters:
//     LONG_CYCLES    hold length classifying a long press (2 .. 2^27-1)
//     REPEAT_CYCLES  period between repeat pulses after a long press
//     REPEAT_EN      1 enables press_repeat, 0 ties it low
// -----------------------------------------------------------------------------
module clasificador_boton #(
   parameter int unsigned LONG_CYCLES   = 100_000_000,
   parameter int unsigned REPEAT_CYCLES = 25_000_000,
   parameter bit          REPEAT_EN     = 1'b1
) (
   input  logic                   clk,
   input  logic                   rst,
   clasificador_boton_if.slave    io_btn
);

   localparam logic [26:0] LP_LONG_LAST   = 27'(LONG_CYCLES - 1);
   localparam logic [26:0] LP_REPEAT_LAST = 27'(REPEAT_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      PRESSED   = 2'd1,
      LONG_HELD = 2'd2
   } state_t;

   state_t      r_state;
   logic [26:0] r_cnt;
   logic        r_armado;
   logic        r_short;
   logic        r_long;
   logic        r_repeat;
   logic        r_pulsado;
   logic        w_boton;

   assign w_boton = io_btn.boton_limpio;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= IDLE;
         r_cnt     <= '0;
         r_armado  <= 1'b0;
         r_short   <= 1'b0;
         r_long    <= 1'b0;
         r_repeat  <= 1'b0;
         r_pulsado <= 1'b0;
      end else begin
         // Pulses last exactly one cycle unless re-asserted below.
         r_short  <= 1'b0;
         r_long   <= 1'b0;
         r_repeat <= 1'b0;

         unique case (r_state)
            IDLE: begin
               // A button held through reset release must be seen low once
               // before it can start a press.
               if (!w_boton) begin
                  r_armado <= 1'b1;
               end else if (r_armado) begin
                  r_state   <= PRESSED;
                  r_cnt     <= '0;
                  r_pulsado <= 1'b1;
               end
            end

            PRESSED: begin
               // Release is tested first so a release on the threshold edge
               // classifies as short, never long.
               if (!w_boton) begin
                  r_state   <= IDLE;
                  r_short   <= 1'b1;
                  r_pulsado <= 1'b0;
               end else if (r_cnt == LP_LONG_LAST) begin
                  r_state <= LONG_HELD;
                  r_long  <= 1'b1;
                  r_cnt   <= '0;
               end else begin
                  r_cnt <= r_cnt + 27'd1;
               end
            end

            LONG_HELD: begin
               if (!w_boton) begin
                  r_state   <= IDLE;
                  r_pulsado <= 1'b0;
               end else if (r_cnt == LP_REPEAT_LAST) begin
                  r_repeat <= REPEAT_EN;
                  r_cnt    <= '0;
               end else begin
                  r_cnt <= r_cnt + 27'd1;
               end
            end

            default: begin
               r_state   <= IDLE;
               r_cnt     <= '0;
               r_pulsado <= 1'b0;
            end
         endcase
      end
   end

   assign io_btn.press_short  = r_short;
   assign io_btn.press_long   = r_long;
   assign io_btn.press_repeat = r_repeat;
   assign io_btn.pulsado      = r_pulsado;

endmodule

// File: tb/tb_clasificador_boton.sv
// -----------------------------------------------------------------------------
// tb_clasificador_boton
//   Directed bench for clasificador_boton with LONG_CYCLES=10, REPEAT_CYCLES=4.
//   Two instances share the same stimulus: u_dut (REPEAT_EN=1) and
//   u_dut_nr (REPEAT_EN=0). Expected outputs are packed as
//   {pulsado, press_repeat, press_long, press_short}.
// -----------------------------------------------------------------------------
module tb_clasificador_boton;

   localparam logic [3:0] Z = 4'b0000;  // nothing
   localparam logic [3:0] P = 4'b1000;  // pulsado only
   localparam logic [3:0] S = 4'b0001;  // press_short, pulsado already low
   localparam logic [3:0] L = 4'b1010;  // press_long while held
   localparam logic [3:0] R = 4'b1100;  // press_repeat while held

   typedef struct {
      string      tag;
      logic [3:0] exp;
   } exp_t;

   logic clk;
   logic rst;
   int   checks;
   int   failures;
   exp_t sb_q[$];

   clasificador_boton_if u_if ();
   clasificador_boton_if u_if_nr ();

   clasificador_boton #(
      .LONG_CYCLES   (10),
      .REPEAT_CYCLES (4),
      .REPEAT_EN     (1'b1)
   ) u_dut (
      .clk    (clk),
      .rst    (rst),
      .io_btn (u_if.slave)
   );

   clasificador_boton #(
      .LONG_CYCLES   (10),
      .REPEAT_CYCLES (4),
      .REPEAT_EN     (1'b0)
   ) u_dut_nr (
      .clk    (clk),
      .rst    (rst),
      .io_btn (u_if_nr.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive n cycles with a fixed input; each cycle pushes its expectation
   // and pops it once the registered outputs have settled after the edge.
   task automatic run(input logic b, input logic r, input int n,
                      input logic [3:0] exp, input string tag);
      exp_t       e;
      logic [3:0] obs;
      logic [3:0] obs_nr;
      logic [3:0] exp_nr;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         u_if.boton_limpio    = b;
         u_if_nr.boton_limpio = b;
         rst                  = r;
         sb_q.push_back('{tag: tag, exp: exp});
         @(posedge clk);
         #1;
         e      = sb_q.pop_front();
         obs    = {u_if.pulsado, u_if.press_repeat, u_if.press_long, u_if.press_short};
         obs_nr = {u_if_nr.pulsado, u_if_nr.press_repeat, u_if_nr.press_long,
                   u_if_nr.press_short};
         exp_nr = e.exp & 4'b1011;
         checks++;
         assert (obs === e.exp) else begin
            failures++;
            $error("FAIL %s[%0d] observed=%b expected=%b", e.tag, i, obs, e.exp);
         end
         checks++;
         assert (obs_nr === exp_nr) else begin
            failures++;
            $error("FAIL %s_norep[%0d] observed=%b expected=%b", e.tag, i, obs_nr, exp_nr);
         end
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      checks               = 0;
      failures             = 0;
      rst                  = 1'b1;
      u_if.boton_limpio    = 1'b0;
      u_if_nr.boton_limpio = 1'b0;

      // Reset then idle low (arms the instance).
      run(1'b0, 1'b1, 3, Z, "reset");
      run(1'b0, 1'b0, 5, Z, "idle_low");

      // Short press: high edges 1..3, low edge 4.
      run(1'b1, 1'b0, 3, P, "short_hold");
      run(1'b0, 1'b0, 1, S, "short_pulse");
      run(1'b0, 1'b0, 2, Z, "short_after");

      // Long press with repeat: high 1..20, low 21.
      run(1'b1, 1'b0, 10, P, "long_pre");
      run(1'b1, 1'b0, 1,  L, "long_pulse");
      run(1'b1, 1'b0, 3,  P, "long_held_a");
      run(1'b1, 1'b0, 1,  R, "repeat_1");
      run(1'b1, 1'b0, 3,  P, "long_held_b");
      run(1'b1, 1'b0, 1,  R, "repeat_2");
      run(1'b1, 1'b0, 1,  P, "long_held_c");
      run(1'b0, 1'b0, 1,  Z, "long_release");
      run(1'b0, 1'b0, 2,  Z, "long_after");

      // Threshold: release on edge 11 is short.
      run(1'b1, 1'b0, 10, P, "thr_short_hold");
      run(1'b0, 1'b0, 1,  S, "thr_short_pulse");
      run(1'b0, 1'b0, 2,  Z, "thr_short_after");

      // Threshold: still held on edge 11 is long, release silent.
      run(1'b1, 1'b0, 10, P, "thr_long_hold");
      run(1'b1, 1'b0, 1,  L, "thr_long_pulse");
      run(1'b0, 1'b0, 1,  Z, "thr_long_release");
      run(1'b0, 1'b0, 2,  Z, "thr_long_after");

      // Held through reset: no events until seen low once.
      run(1'b1, 1'b1, 2,  Z, "held_rst");
      run(1'b1, 1'b0, 15, Z, "held_unarmed");
      run(1'b0, 1'b0, 1,  Z, "held_rearm");
      run(1'b1, 1'b0, 3,  P, "rearm_hold");
      run(1'b0, 1'b0, 1,  S, "rearm_short");
      run(1'b0, 1'b0, 2,  Z, "rearm_after");

      // Reset on edge 6 of a hold discards it.
      run(1'b1, 1'b0, 5,  P, "mid_hold");
      run(1'b1, 1'b1, 1,  Z, "mid_rst");
      run(1'b1, 1'b0, 12, Z, "mid_post_rst");
      run(1'b0, 1'b0, 2,  Z, "mid_release");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/clasificador_boton.md
Name: clasificador_boton

Overview:
- Consumes the clean, debounced button level produced by the team's debouncer and turns it into one-cycle event pulses for the Tamagotchi control FSM.
- Emits three events: short press (released before the long threshold), long press (hold reaches the threshold), and auto-repeat (periodic pulses while held past long).
- One instance per button; sits between the debouncer output and the game/menu logic, in the same 50 MHz domain.

Parameters:
- LONG_CYCLES, 100_000_000, hold length in clk cycles that classifies a long press (2 s at 50 MHz); legal range 2 to 2^27-1.
- REPEAT_CYCLES, 25_000_000, period in clk cycles between repeat pulses after a long press (0.5 s); legal range 2 to 2^27-1.
- REPEAT_EN, 1, 1 enables press_repeat; 0 ties it low.

Ports:
- clk  input  1  system clock, 50 MHz, all logic on posedge.
- rst  input  1  synchronous active-high reset.
- boton_limpio  input  1  debounced button level, 1 = pressed; already synchronous to clk.
- press_short  output  1  one-cycle pulse on release of a press shorter than LONG_CYCLES.
- press_long  output  1  one-cycle pulse when the hold reaches LONG_CYCLES.
- press_repeat  output  1  one-cycle pulse every REPEAT_CYCLES while held after press_long.
- pulsado  output  1  level, 1 while the FSM is in PRESSED or LONG_HELD.

Behaviour:
- Sampling and output timing:
  - All outputs are registered.
  - "Edge n" means the posedge at which boton_limpio is sampled.
  - A pulse is high for exactly the one cycle following the edge that generates it.
- Reset (rst=1 at a posedge):
  - state=IDLE, counter=0, armado=0.
  - press_short, press_long, press_repeat and pulsado are all 0.
  - Reset overrides any event on the same edge; a reset during a hold discards it with no pulse.
- Arming:
  - armado is set at the first edge where boton_limpio=0 while in IDLE.
  - A button held through reset release produces no events until it has been seen low once.
- Counter: 27-bit unsigned; never wraps in practice because it is cleared before reaching its limit.
- States:
  - IDLE:
    - boton_limpio=1 and armado=1 -> PRESSED, counter<=0, pulsado<=1.
    - Otherwise remain in IDLE.
  - PRESSED:
    - boton_limpio=0 -> IDLE, press_short<=1, pulsado<=0.
    - boton_limpio=1 and counter==LONG_CYCLES-1 -> LONG_HELD, press_long<=1, counter<=0.
    - Otherwise counter<=counter+1.
    - Net effect: press_long is high in the cycle after the edge LONG_CYCLES edges after the entry edge.
  - LONG_HELD:
    - boton_limpio=0 -> IDLE, pulsado<=0, no pulse.
    - boton_limpio=1 and counter==REPEAT_CYCLES-1 -> press_repeat<=REPEAT_EN, counter<=0.
    - Otherwise counter<=counter+1.
- Exclusivity: at most one of the three pulse outputs is high in any cycle; press_short and press_long never both occur for the same press.
- Release on the threshold edge: release wins. If boton_limpio=0 on the edge where counter==LONG_CYCLES-1, the result is press_short, not press_long.
- The block performs no debouncing of its own; glitches on boton_limpio are treated as real presses.

Test Plan (bench params: LONG_CYCLES=10, REPEAT_CYCLES=4, REPEAT_EN=1):
- Reset then idle low: hold rst 3 cycles, input low 5 cycles -> all outputs 0, pulsado 0.
- Short press: input high for edges 1..3, low at edge 4 -> pulsado=1 after edges 1..3; press_short=1 for exactly the cycle after edge 4; no press_long.
- Long press with repeat: input high from edge 1 to 20, low at edge 21:
  - press_long after edge 11.
  - press_repeat after edges 15 and 19.
  - No pulse at release; pulsado falls after edge 21.
- Threshold boundary: input high for edges 1..10, low at edge 11 -> press_short after edge 11, press_long never asserted. Repeat with high through edge 11 -> press_long after edge 11, no press_short at release.
- Held through reset: input high while rst=1 and for 15 cycles after -> no pulses, pulsado=0. Then drop low, then press 3 cycles -> press_short as in the short-press case.
- Reset mid-hold, plus REPEAT_EN=0 variant:
  - rst at edge 6 of a hold -> outputs 0 next cycle, no pulse later even on release.
  - With REPEAT_EN=0, a 20-cycle hold yields press_long only.
